alu_sequencer: RTL and testbench

Accumulator-style command sequencer that drives the 8-bit ALU datapath (A, B, fs in; C, 4-bit flag out). It accepts one command at a time over a valid/ready port and issues the matching operation to the combinational ALU. It captures C and flag into an accumulator and flag register, then returns the result over a valid/ready response port. It is the control-side counterpart to the ALU and sits between the instruction front end and the ALU instance.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_sequencer.sv | 89 ++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command, ALU-datapath and response bundle for alu_sequencer.
// slave = sequencer view; master = front end / ALU / consumer view.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_fs;
  logic [7:0] alu_c;
  logic [3:0] alu_flag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flag;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, alu_c, alu_flag, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fs, rsp_valid, rsp_data, rsp_flag, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_operand, alu_c, alu_flag, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fs, rsp_valid, rsp_data, rsp_flag, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator command sequencer driving an 8-bit combinational ALU (IDLE/EXEC/RESP).
// Optional zero-flag cross-check enabled by defining ALU_SEQ_ZCHK_EN.
module alu_sequencer (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;
  localparam logic [1:0] FS_ADD  = 2'b00;
  localparam logic [1:0] FS_SUB  = 2'b01;
  localparam logic [1:0] FS_CMP  = 2'b10;
  localparam logic [1:0] FS_IDLE = 2'b11;

  state_t     state;
  logic [1:0] op;
  logic [7:0] acc;
  logic [3:0] flag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_fs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= OP_LDA;
      acc    <= 8'h00;
      flag   <= 4'h0;
      alu_a  <= 8'h00;
      alu_b  <= 8'h00;
      alu_fs <= FS_IDLE;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op    <= bus.cmd_op;
          alu_a <= (bus.cmd_op == OP_LDA) ? 8'h00 : acc;
          alu_b <= bus.cmd_operand;
          case (bus.cmd_op)
            OP_SUB:  alu_fs <= FS_SUB;
            OP_CMP:  alu_fs <= FS_CMP;
            default: alu_fs <= FS_ADD;
          endcase
          state <= EXEC;
        end
        EXEC: begin
          // cmp leaves C and zero undefined, so only the compare bit is taken
          if (op == OP_CMP) begin
            flag <= {bus.alu_flag[3], 3'b000};
          end else begin
            acc  <= bus.alu_c;
            flag <= {1'b0, bus.alu_flag[2], 1'b0, bus.alu_flag[0]};
          end
          alu_fs <= FS_IDLE;
          state  <= RESP;
        end
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ZCHK_EN
  logic err;
  logic zero_bad;

  assign zero_bad = (state == EXEC) && (op != OP_CMP) &&
                    ((bus.alu_c == 8'h00) != bus.alu_flag[2]);

  always_ff @(posedge clk) begin
    if (!rst_n)        err <= 1'b0;
    else if (zero_bad) err <= 1'b1;
  end

  assign bus.rsp_err = err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = acc;
  assign bus.rsp_flag  = flag;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_fs    = alu_fs;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed commands push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_sequencer;
`ifdef ALU_SEQ_ZCHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flag;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  alu_seq_if bus();

  alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // ALU model; reserved bit driven 1 and cmp-mode C/zero/carry are junk on purpose
  logic       zbad = 1'b0;
  logic [8:0] m_s;
  logic [7:0] m_c;
  logic [3:0] m_f;
  always_comb begin
    m_s = 9'h000;
    m_c = 8'h00;
    m_f = 4'h0;
    case (bus.alu_fs)
      2'b00: begin
        m_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_c = m_s[7:0];
        m_f = {1'b0, (m_s[7:0] == 8'h00), 1'b1, m_s[8]};
      end
      2'b01: begin
        m_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_c = m_s[7:0];
        m_f = {1'b0, (m_s[7:0] == 8'h00), 1'b1, m_s[8]};
      end
      2'b10: begin
        m_c = 8'hA5;
        m_f = {(bus.alu_a == bus.alu_b), 3'b111};
      end
      default: begin
        m_c = 8'h00;
        m_f = 4'h0;
      end
    endcase
    if (zbad) m_f[2] = 1'b0;
  end
  assign bus.alu_c    = m_c;
  assign bus.alu_flag = m_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got data 0x%0h with empty scoreboard", bus.rsp_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", {24'h0, bus.rsp_data}, {24'h0, e.data});
        chk("rsp_flag", {28'h0, bus.rsp_flag}, {28'h0, e.flag});
        chk("rsp_err",  {31'h0, bus.rsp_err},  {31'h0, e.err});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] opd, input bit push,
                       input logic [7:0] ed, input logic [3:0] ef, input logic ee);
    int n;
    n = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = opd;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd_ready 0 after %0d cycles, expected 1", n);
    end else if (push) begin
      exp_q.push_back('{data: ed, flag: ef, err: ee});
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: cmd_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_operand = 8'h00;
    bus.rsp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_data",  {24'h0, bus.rsp_data},  32'h00);
    chk("rst_rsp_flag",  {28'h0, bus.rsp_flag},  32'h0);
    chk("rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
    chk("rst_alu_fs",    {30'h0, bus.alu_fs},    32'h3);
    chk("rst_alu_a",     {24'h0, bus.alu_a},     32'h00);
    chk("rst_alu_b",     {24'h0, bus.alu_b},     32'h00);

    // LDA 0x7F with latency tracking
    issue(2'b00, 8'h7F, 1'b1, 8'h7F, 4'b0000, 1'b0);
    @(negedge clk);
    chk("lda_exec_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("lda_exec_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("lda_exec_alu_a",     {24'h0, bus.alu_a},     32'h00);
    chk("lda_exec_alu_b",     {24'h0, bus.alu_b},     32'h7F);
    chk("lda_exec_alu_fs",    {30'h0, bus.alu_fs},    32'h0);
    @(negedge clk);
    chk("lda_resp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("lda_resp_alu_fs",    {30'h0, bus.alu_fs},    32'h3);
    chk("lda_resp_alu_b",     {24'h0, bus.alu_b},     32'h7F);
    @(negedge clk);
    chk("lda_after_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    @(posedge clk);
    #1;

    issue(2'b01, 8'h81, 1'b1, 8'h00, 4'b0101, 1'b0);  // 7F+81 -> 00 carry zero
    wait_idle();
    issue(2'b10, 8'h01, 1'b1, 8'hFF, 4'b0001, 1'b0);  // 00-01 -> FF borrow
    wait_idle();
    issue(2'b11, 8'hFF, 1'b1, 8'hFF, 4'b1000, 1'b0);  // equal
    wait_idle();
    issue(2'b11, 8'h10, 1'b1, 8'hFF, 4'b0000, 1'b0);  // not equal, ACC kept
    wait_idle();
    issue(2'b01, 8'h01, 1'b1, 8'h00, 4'b0101, 1'b0);  // FF+01 wrap
    wait_idle();
    issue(2'b10, 8'h00, 1'b1, 8'h00, 4'b0100, 1'b0);  // 00-00 no borrow
    wait_idle();
    issue(2'b01, 8'h90, 1'b1, 8'h90, 4'b0000, 1'b0);
    wait_idle();
    issue(2'b10, 8'h10, 1'b1, 8'h80, 4'b0000, 1'b0);
    wait_idle();

    // Backpressure with a second command waiting
    bus.rsp_ready = 1'b0;
    issue(2'b00, 8'h3C, 1'b1, 8'h3C, 4'b0000, 1'b0);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = 2'b01;
    bus.cmd_operand = 8'h11;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      chk("bp_rsp_data",  {24'h0, bus.rsp_data},  32'h3C);
      chk("bp_rsp_flag",  {28'h0, bus.rsp_flag},  32'h0);
      chk("bp_alu_b",     {24'h0, bus.alu_b},     32'h3C);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    exp_q.push_back('{data: 8'h4D, flag: 4'b0000, err: 1'b0});
    @(posedge clk);
    #1;
    chk("bp_hs_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("bp_hs_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("bp_acc2_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("bp_acc2_alu_a",     {24'h0, bus.alu_a},     32'h3C);
    chk("bp_acc2_alu_b",     {24'h0, bus.alu_b},     32'h11);
    chk("bp_acc2_alu_fs",    {30'h0, bus.alu_fs},    32'h0);
    bus.cmd_valid = 1'b0;
    wait_idle();

    // Zero-flag corruption: 4D+B3 -> 00 with zero forced low
    zbad = 1'b1;
    issue(2'b01, 8'hB3, 1'b1, 8'h00, 4'b0001, ZCHK);
    wait_idle();
    zbad = 1'b0;
    issue(2'b00, 8'h20, 1'b1, 8'h20, 4'b0000, ZCHK);
    wait_idle();
    issue(2'b01, 8'hE0, 1'b1, 8'h00, 4'b0101, ZCHK);
    wait_idle();

    // Reset during EXEC of ADD 0x05
    issue(2'b00, 8'h44, 1'b1, 8'h44, 4'b0000, ZCHK);
    wait_idle();
    issue(2'b01, 8'h05, 1'b0, 8'h00, 4'b0000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mid_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("mid_rst_rsp_data",  {24'h0, bus.rsp_data},  32'h00);
    chk("mid_rst_rsp_flag",  {28'h0, bus.rsp_flag},  32'h0);
    chk("mid_rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
    chk("mid_rst_alu_fs",    {30'h0, bus.alu_fs},    32'h3);
    chk("mid_rst_alu_a",     {24'h0, bus.alu_a},     32'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);

    issue(2'b01, 8'h05, 1'b1, 8'h05, 4'b0000, 1'b0);  // ACC restarted from 0
    wait_idle();
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
